cis_cds_accumulator: RTL and testbench
======================================

# cis_cds_accumulator

Downstream of the CIS pixel sequencer: captures SPROCKET ADC conversions tagged by `sprocket_phi1` (baseline) and `sprocket_phi2` (signal). It accumulates the correlated-double-sample difference over `skip_samples` skipper repetitions and emits one signed sum per pixel through a valid/ready output. It drives `sprocket_eoc` back to the sequencer so global-shutter pixel clustering can advance.

## Interface
- `ADC_BITS`, 12, ADC sample width (unsigned).
- `ACC_BITS`, `ADC_BITS+11`, signed accumulator/output width; holds ±(2^ADC_BITS−1)·1023.
- `OUT_DEPTH`, 2, output FIFO depth (≥2).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `skip_samples` in 10: CDS pairs per pixel; 0 treated as 1.
- `sprocket_phi1` in 1: baseline-phase strobe from sequencer.
- `sprocket_phi2` in 1: signal-phase strobe from sequencer.
- `row_rst` in 1: sync clear of pixel index, aborts the current accumulation.
- `adc_valid` in 1: one-cycle pulse, `adc_data` valid.
- `adc_data` in `ADC_BITS`: conversion result.
- `sprocket_eoc` out 1: pixel result committed; level signal.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_data` out `ACC_BITS`: signed Σ(signal − baseline).
- `out_pixel` out 4: pixel index within cluster (0–15).
- `err_count` out 8: only with `CDS_ERR_CNT_EN`.

## Operation
- Edge detect: registered `phi1_q`, `phi2_q` (reset 0). A rise is `phi & ~phi_q`.
- FSM (reset IDLE):
  - IDLE: on phi1 rise, latch `n = max(skip_samples,1)`, clear acc and `sample_cnt`, go WAIT_BASE.
  - WAIT_BASE: on `adc_valid`, store baseline, go ARM_SIG.
  - ARM_SIG: on phi2 rise, go WAIT_SIG.
  - WAIT_SIG: on `adc_valid`, add `acc += signed(adc_data) − signed(baseline)` at `ADC_BITS+1`, sign-extended. Increment `sample_cnt`. If the new count == n, go EMIT; else go ARM_BASE.
  - ARM_BASE: on phi1 rise, go WAIT_BASE. Acc and n are kept; `skip_samples` is not re-sampled mid-pixel.
  - EMIT: if FIFO not full, push {acc, pixel_idx}, set `sprocket_eoc`, increment pixel_idx (15 wraps to 0), go IDLE. If FIFO is full, stay in EMIT and keep `sprocket_eoc` low.
- `sprocket_eoc`: set on the EMIT push. Cleared on the next phi1 rise or on `row_rst`. Being a level, it survives a divided sequencer clock.
- Protocol errors (counted if enabled, otherwise ignored, state unchanged):
  - `adc_valid` in IDLE/ARM_SIG/ARM_BASE/EMIT.
  - phi rise of the wrong phase.
  - phi1 and phi2 rising in the same cycle.
- `row_rst` (priority below `reset`, above all else): go IDLE, pixel_idx=0, clear acc/`sample_cnt`/`sprocket_eoc`. FIFO contents are preserved.
- FIFO: push and pop in the same cycle are allowed when full, provided the pop is decided first, so EMIT proceeds. `out_*` are driven from the FIFO head.

## Timing
- Reset values:
  - 0: `out_valid`, `out_data`, `out_pixel`, `sprocket_eoc`, `err_count`.
  - FSM in IDLE, FIFO empty.
- `adc_valid` of the last signal sample at cycle t: acc updated at t+1 (EMIT), then `out_valid` and `sprocket_eoc` high at t+2 if space was available.
- Edge detection adds no extra latency: a phi rise seen at t changes state at t+1.
- `out_data`/`out_pixel` stay stable while `out_valid && !out_ready`.
- `adc_valid` coinciding with the phi rise that arms its phase is an error; the arm takes effect the next cycle.

## Configuration
- `CDS_ERR_CNT_EN` defined: the `err_count` port exists. It is an 8-bit saturating counter (stops at 255), incremented once per cycle containing ≥1 protocol error, and cleared by `reset` only.
- `CDS_ERR_CNT_EN` undefined: port and logic are absent; errors are silently ignored with identical functional behaviour.

## Structure
- Shared `cis_pkg`:
  - `cds_state_t` enum (IDLE, WAIT_BASE, ARM_SIG, WAIT_SIG, ARM_BASE, EMIT).
  - `PIXEL_CLUSTER_SIZE=16`.
  - Default `ADC_BITS`.
- One sub-module, `cds_out_fifo`: parameterised depth/width, synchronous, with full/empty and show-ahead output.

## Test plan
- skip_samples=1, baseline 100, signal 612 → out_data=512, out_pixel=0, eoc high at t+2 after signal `adc_valid`, and low after the next phi1 rise.
- skip_samples=4, pairs (1000,900)×4 → out_data=−400 once, with no intermediate output.
- skip_samples=1023, full-scale (0,4095) every pair → out_data=4189185, no overflow. skip_samples=0 behaves as 1.
- out_ready=0 across 3 pixels (values 1,2,3) → FIFO holds 1,2. Third pixel stalls in EMIT with eoc low; eoc rises when out_ready=1 pops. Output order is 1,2,3 with pixels 0,1,2.
- 17 pixels → out_pixel wraps 15→0. `row_rst` mid-WAIT_SIG → no output, next pixel index 0, queued FIFO entries still delivered.
- With `CDS_ERR_CNT_EN`: stray `adc_valid` in IDLE plus simultaneous phi1/phi2 rise → err_count=2, no state change. 300 errors → err_count=255.

Source files
------------

// File: rtl/cis_pkg.sv
// cis_pkg: shared types and constants for the CIS readout blocks.
//   cds_state_t        - CDS accumulator FSM states
//   PIXEL_CLUSTER_SIZE - pixels per global-shutter cluster (pixel index range)
//   ADC_BITS_DEFAULT   - default SPROCKET ADC sample width
//   cds_eff_skip()     - skipper repetition count with 0 promoted to 1
package cis_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BASE = 3'd1,
        ARM_SIG   = 3'd2,
        WAIT_SIG  = 3'd3,
        ARM_BASE  = 3'd4,
        EMIT      = 3'd5
    } cds_state_t;

    localparam int PIXEL_CLUSTER_SIZE = 16;
    localparam int PIXEL_IDX_BITS     = $clog2(PIXEL_CLUSTER_SIZE);
    localparam int ADC_BITS_DEFAULT   = 12;

    // A zero repetition count would never terminate a pixel, so run one pair.
    function automatic logic [9:0] cds_eff_skip(input logic [9:0] skip);
        if (skip == 10'd0) begin
            return 10'd1;
        end else begin
            return skip;
        end
    endfunction

endpackage

// File: rtl/cds_out_fifo.sv
// cds_out_fifo: synchronous show-ahead FIFO for CDS results.
//   clk, reset (async, active-high)
//   push, wr_data : write side; a push while full is accepted only when a pop
//                   happens in the same cycle
//   pop           : read side; ignored when empty
//   rd_data       : head entry (valid whenever !empty)
//   full, empty   : occupancy flags
module cds_out_fifo
    import cis_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr_r;
    logic [PTR_BITS-1:0] wr_ptr_r;
    logic [CNT_BITS-1:0] count_r;
    logic                pop_s;
    logic                push_s;

    function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
        if (p == PTR_BITS'(DEPTH - 1)) begin
            return {PTR_BITS{1'b0}};
        end else begin
            return p + PTR_BITS'(1);
        end
    endfunction

    assign full    = (count_r == CNT_BITS'(DEPTH));
    assign empty   = (count_r == CNT_BITS'(0));
    // Pop is resolved first so a full FIFO can still take a push in the same cycle.
    assign pop_s   = pop & ~empty;
    assign push_s  = push & (~full | pop_s);
    assign rd_data = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r <= {PTR_BITS{1'b0}};
            wr_ptr_r <= {PTR_BITS{1'b0}};
            count_r  <= {CNT_BITS{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_BITS'(1);
                2'b01:   count_r <= count_r - CNT_BITS'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cis_cds_accumulator.sv
// cis_cds_accumulator: correlated-double-sample accumulator for SPROCKET ADC
// conversions. Pairs a baseline (phi1 phase) and a signal (phi2 phase)
// conversion, sums (signal - baseline) over skip_samples repetitions and
// queues one signed result per pixel.
//   clk, reset (async, active-high), row_rst (sync abort / pixel index clear)
//   skip_samples          : CDS pairs per pixel (0 behaves as 1)
//   sprocket_phi1/phi2    : phase strobes, rising edges are used
//   adc_valid, adc_data   : conversion results
//   sprocket_eoc          : level, high once the pixel result is queued
//   out_valid/ready/data/pixel : result stream from the FIFO head
//   err_count             : saturating protocol error count, present only
//                           when CDS_ERR_CNT_EN is defined
module cis_cds_accumulator
    import cis_pkg::*;
#(
    parameter int ADC_BITS  = ADC_BITS_DEFAULT,
    parameter int ACC_BITS  = ADC_BITS + 11,
    parameter int OUT_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                skip_samples,
    input  logic                      sprocket_phi1,
    input  logic                      sprocket_phi2,
    input  logic                      row_rst,
    input  logic                      adc_valid,
    input  logic [ADC_BITS-1:0]       adc_data,
    output logic                      sprocket_eoc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_BITS-1:0]       out_data,
    output logic [PIXEL_IDX_BITS-1:0] out_pixel
`ifdef CDS_ERR_CNT_EN
    ,
    output logic [7:0]                err_count
`endif
);

    cds_state_t                state_r, state_s;
    logic                      phi1_q_r, phi2_q_r;
    logic                      phi1_rise_s, phi2_rise_s, both_rise_s;
    logic                      phi1_ok_s, phi2_ok_s;
    logic [9:0]                n_r, sample_cnt_r;
    logic [ADC_BITS-1:0]       baseline_r;
    logic [ACC_BITS-1:0]       acc_r;
    logic [ADC_BITS:0]         diff_s;
    logic [PIXEL_IDX_BITS-1:0] pixel_idx_r;
    logic                      eoc_r;
    logic                      start_s, base_load_s, sig_add_s, push_s, err_s;
    logic                      fifo_full_s, fifo_empty_s;

    assign phi1_rise_s = sprocket_phi1 & ~phi1_q_r;
    assign phi2_rise_s = sprocket_phi2 & ~phi2_q_r;
    assign both_rise_s = phi1_rise_s & phi2_rise_s;
    // Simultaneous rises are a protocol error and must not advance anything.
    assign phi1_ok_s   = phi1_rise_s & ~phi2_rise_s;
    assign phi2_ok_s   = phi2_rise_s & ~phi1_rise_s;
    // Both operands zero-extended, so the top bit is the sign of the difference.
    assign diff_s      = {1'b0, adc_data} - {1'b0, baseline_r};

    // Phase strobe history for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi1_q_r <= 1'b0;
            phi2_q_r <= 1'b0;
        end else begin
            phi1_q_r <= sprocket_phi1;
            phi2_q_r <= sprocket_phi2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state, datapath strobes and protocol error detection.
    always_comb begin
        state_s     = state_r;
        start_s     = 1'b0;
        base_load_s = 1'b0;
        sig_add_s   = 1'b0;
        push_s      = 1'b0;
        err_s       = 1'b0;
        if (row_rst) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    err_s = adc_valid | phi2_ok_s;
                    if (phi1_ok_s) begin
                        start_s = 1'b1;
                        state_s = WAIT_BASE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT_BASE: begin
                    err_s = phi2_ok_s;
                    if (adc_valid) begin
                        base_load_s = 1'b1;
                        state_s     = ARM_SIG;
                    end else begin
                        state_s = WAIT_BASE;
                    end
                end
                ARM_SIG: begin
                    err_s = adc_valid | phi1_ok_s;
                    if (phi2_ok_s) begin
                        state_s = WAIT_SIG;
                    end else begin
                        state_s = ARM_SIG;
                    end
                end
                WAIT_SIG: begin
                    err_s = phi1_ok_s;
                    if (adc_valid) begin
                        sig_add_s = 1'b1;
                        if ((sample_cnt_r + 10'd1) == n_r) begin
                            state_s = EMIT;
                        end else begin
                            state_s = ARM_BASE;
                        end
                    end else begin
                        state_s = WAIT_SIG;
                    end
                end
                ARM_BASE: begin
                    err_s = adc_valid | phi2_ok_s;
                    if (phi1_ok_s) begin
                        state_s = WAIT_BASE;
                    end else begin
                        state_s = ARM_BASE;
                    end
                end
                EMIT: begin
                    err_s = adc_valid | phi2_ok_s;
                    // A pop this cycle frees the slot even when the FIFO reads full.
                    if (!fifo_full_s || (out_ready && !fifo_empty_s)) begin
                        push_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = EMIT;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
            err_s = err_s | both_rise_s;
        end
    end

    // Accumulator, repetition bookkeeping, pixel index and end-of-conversion flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_r          <= 10'd1;
            sample_cnt_r <= 10'd0;
            baseline_r   <= {ADC_BITS{1'b0}};
            acc_r        <= {ACC_BITS{1'b0}};
            pixel_idx_r  <= {PIXEL_IDX_BITS{1'b0}};
            eoc_r        <= 1'b0;
        end else if (row_rst) begin
            sample_cnt_r <= 10'd0;
            acc_r        <= {ACC_BITS{1'b0}};
            pixel_idx_r  <= {PIXEL_IDX_BITS{1'b0}};
            eoc_r        <= 1'b0;
        end else begin
            if (start_s) begin
                n_r          <= cds_eff_skip(skip_samples);
                sample_cnt_r <= 10'd0;
                acc_r        <= {ACC_BITS{1'b0}};
            end
            if (base_load_s) begin
                baseline_r <= adc_data;
            end
            if (sig_add_s) begin
                acc_r        <= acc_r + {{(ACC_BITS-ADC_BITS-1){diff_s[ADC_BITS]}}, diff_s};
                sample_cnt_r <= sample_cnt_r + 10'd1;
            end
            // Index wraps 15 -> 0 through natural overflow of the 4-bit counter.
            if (push_s) begin
                pixel_idx_r <= pixel_idx_r + {{(PIXEL_IDX_BITS-1){1'b0}}, 1'b1};
                eoc_r       <= 1'b1;
            end else if (phi1_ok_s) begin
                eoc_r <= 1'b0;
            end
        end
    end

    assign sprocket_eoc = eoc_r;

    cds_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ACC_BITS + PIXEL_IDX_BITS)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .wr_data ({acc_r, pixel_idx_r}),
        .pop     (out_ready),
        .rd_data ({out_data, out_pixel}),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign out_valid = ~fifo_empty_s;

`ifdef CDS_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of cycles that contain at least one protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_r <= 8'd0;
        end else if (err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_count = err_cnt_r;
`else
    logic err_unused_s;
    assign err_unused_s = err_s;
`endif

endmodule

// File: tb/tb_cis_cds_accumulator.sv
module tb_cis_cds_accumulator;

    logic        clk;
    logic        reset;
    logic [9:0]  skip_samples;
    logic        sprocket_phi1;
    logic        sprocket_phi2;
    logic        row_rst;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        sprocket_eoc;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_data;
    logic [3:0]  out_pixel;
`ifdef CDS_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int checks;
    int errors;

    cis_cds_accumulator dut (
        .clk           (clk),
        .reset         (reset),
        .skip_samples  (skip_samples),
        .sprocket_phi1 (sprocket_phi1),
        .sprocket_phi2 (sprocket_phi2),
        .row_rst       (row_rst),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .sprocket_eoc  (sprocket_eoc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_pixel     (out_pixel)
`ifdef CDS_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int skip;
        int base;
        int sig;
        int pairs;
        int exp_data;
        int exp_pix;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Check the FIFO head then pop it with a one-cycle out_ready.
    task automatic pop_check(input int exp_data, input int exp_pix);
        chk("pop_valid", {31'd0, out_valid}, 1);
        chk("pop_data", $signed(out_data), exp_data);
        chk("pop_pixel", {28'd0, out_pixel}, exp_pix);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Drive `pairs` baseline/signal pairs; returns one edge after the last
    // signal sample (DUT in EMIT). skip_samples is disturbed after pair 0.
    task automatic do_pixel(input int skip, input int base, input int sig,
                            input int pairs, input bit chk_mid);
        skip_samples = 10'(skip);
        for (int p = 0; p < pairs; p++) begin
            sprocket_phi1 = 1'b1;
            tick();
            sprocket_phi1 = 1'b0;
            if (p == 0) chk("eoc_clear_on_phi1", {31'd0, sprocket_eoc}, 0);
            adc_valid = 1'b1;
            adc_data  = 12'(base);
            tick();
            adc_valid = 1'b0;
            sprocket_phi2 = 1'b1;
            tick();
            sprocket_phi2 = 1'b0;
            adc_valid = 1'b1;
            adc_data  = 12'(sig);
            tick();
            adc_valid = 1'b0;
            if (pairs > 1) skip_samples = 10'd7;
            if (chk_mid && (p < pairs - 1)) chk("no_mid_output", {31'd0, out_valid}, 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        skip_samples = 10'd1;
        sprocket_phi1 = 1'b0;
        sprocket_phi2 = 1'b0;
        row_rst = 1'b0;
        adc_valid = 1'b0;
        adc_data = 12'd0;
        out_ready = 1'b0;

        vecs[0] = '{skip: 1,    base: 100,  sig: 612,  pairs: 1,    exp_data: 512,     exp_pix: 0};
        vecs[1] = '{skip: 4,    base: 1000, sig: 900,  pairs: 4,    exp_data: -400,    exp_pix: 1};
        vecs[2] = '{skip: 1023, base: 0,    sig: 4095, pairs: 1023, exp_data: 4189185, exp_pix: 2};
        vecs[3] = '{skip: 0,    base: 10,   sig: 20,   pairs: 1,    exp_data: 10,      exp_pix: 3};
        vecs[4] = '{skip: 2,    base: 4095, sig: 0,    pairs: 2,    exp_data: -8190,   exp_pix: 4};
        vecs[5] = '{skip: 3,    base: 5,    sig: 5,    pairs: 3,    exp_data: 0,       exp_pix: 5};

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_out_pixel", {28'd0, out_pixel}, 0);
        chk("rst_eoc", {31'd0, sprocket_eoc}, 0);
`ifdef CDS_ERR_CNT_EN
        chk("rst_err_count", {24'd0, err_count}, 0);
`endif
        reset = 1'b0;
        tick();

        // Protocol errors in IDLE: stray adc_valid, then simultaneous rises
        adc_valid = 1'b1;
        adc_data  = 12'd33;
        tick();
        adc_valid = 1'b0;
        sprocket_phi1 = 1'b1;
        sprocket_phi2 = 1'b1;
        tick();
        sprocket_phi1 = 1'b0;
        sprocket_phi2 = 1'b0;
        tick();
        chk("err_no_output", {31'd0, out_valid}, 0);
        chk("err_no_eoc", {31'd0, sprocket_eoc}, 0);
`ifdef CDS_ERR_CNT_EN
        chk("err_count_2", {24'd0, err_count}, 2);
`endif

        // Table of single-pixel vectors (state must still be IDLE, index 0)
        for (int i = 0; i < 6; i++) begin
            do_pixel(vecs[i].skip, vecs[i].base, vecs[i].sig, vecs[i].pairs, 1'b1);
            chk("eoc_low_t1", {31'd0, sprocket_eoc}, 0);
            chk("valid_low_t1", {31'd0, out_valid}, 0);
            tick();
            chk("eoc_high_t2", {31'd0, sprocket_eoc}, 1);
            pop_check(vecs[i].exp_data, vecs[i].exp_pix);
            chk("fifo_empty_after_pop", {31'd0, out_valid}, 0);
        end

        // Backpressure: three pixels with out_ready low
        row_rst = 1'b1;
        tick();
        row_rst = 1'b0;
        chk("row_rst_eoc", {31'd0, sprocket_eoc}, 0);
        do_pixel(1, 0, 1, 1, 1'b0);
        tick();
        chk("bp_eoc_p0", {31'd0, sprocket_eoc}, 1);
        do_pixel(1, 0, 2, 1, 1'b0);
        tick();
        chk("bp_eoc_p1", {31'd0, sprocket_eoc}, 1);
        do_pixel(1, 0, 3, 1, 1'b0);
        tick();
        tick();
        chk("bp_stall_eoc_low", {31'd0, sprocket_eoc}, 0);
        chk("bp_head_stable", $signed(out_data), 1);
        tick();
        chk("bp_stall_eoc_low2", {31'd0, sprocket_eoc}, 0);
        pop_check(1, 0);
        chk("bp_eoc_after_pop", {31'd0, sprocket_eoc}, 1);
        pop_check(2, 1);
        pop_check(3, 2);
        chk("bp_drained", {31'd0, out_valid}, 0);

        // 17 pixels: index wraps 15 -> 0
        row_rst = 1'b1;
        tick();
        row_rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            do_pixel(1, 0, i + 1, 1, 1'b0);
            tick();
            pop_check(i + 1, i % 16);
        end

        // row_rst during WAIT_SIG with one result queued
        do_pixel(1, 0, 7, 1, 1'b0);
        tick();
        sprocket_phi1 = 1'b1;
        tick();
        sprocket_phi1 = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 12'd5;
        tick();
        adc_valid = 1'b0;
        sprocket_phi2 = 1'b1;
        tick();
        sprocket_phi2 = 1'b0;
        row_rst = 1'b1;
        tick();
        row_rst = 1'b0;
        chk("abort_eoc", {31'd0, sprocket_eoc}, 0);
        adc_valid = 1'b1;
        adc_data  = 12'd50;
        tick();
        adc_valid = 1'b0;
        tick();
        tick();
        pop_check(7, 1);
        chk("abort_no_output", {31'd0, out_valid}, 0);
        do_pixel(1, 0, 9, 1, 1'b0);
        tick();
        pop_check(9, 0);

`ifdef CDS_ERR_CNT_EN
        chk("err_count_3", {24'd0, err_count}, 3);
        adc_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        adc_valid = 1'b0;
        tick();
        chk("err_count_sat", {24'd0, err_count}, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
